// File: rtl/uart_tx_buffered_pkg.sv
// rtl/uart_tx_buffered_pkg.sv - shared UART transmitter states and constants
package uart_tx_buffered_pkg;

    // Transmitter FSM states, 2-bit encoding shared with the CPU top level
    typedef enum logic [1:0] {
        UART_ST_IDLE  = 2'd0,
        UART_ST_START = 2'd1,
        UART_ST_DATA  = 2'd2,
        UART_ST_STOP  = 2'd3
    } uart_state_t;

    // Store address the MA stage decodes as a UART byte write
    localparam logic [31:0] UART_ADDR = 32'h0000_1000;

    // 100 MHz system clock / 115200 baud
    localparam int UART_CLKS_PER_BIT = 868;

    // Data bits per 8N1 frame
    localparam int UART_DATA_BITS = 8;

endpackage

// File: rtl/uart_tx_buffered_if.sv
// rtl/uart_tx_buffered_if.sv - byte write port and status flags of the UART transmitter
interface uart_tx_buffered_if;

    logic       wr_en;
    logic [7:0] wr_data;
    logic       full;
    logic       empty;
    logic       busy;
    logic       overflow;

    // Producer side (memory-access stage)
    modport master (
        output wr_en, wr_data,
        input  full, empty, busy, overflow
    );

    // Transmitter side
    modport slave (
        input  wr_en, wr_data,
        output full, empty, busy, overflow
    );

endinterface

// File: rtl/uart_tx_buffered_sync_fifo.sv
// rtl/uart_tx_buffered_sync_fifo.sv - synchronous FIFO with registered full/empty/count
module uart_tx_buffered_sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16,
    parameter int PTR_W = 4
) (
    input  logic             clk,
    input  logic             nrst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head,
    output logic             full,
    output logic             empty,
    output logic [PTR_W:0]   count
);

    localparam logic [PTR_W:0] DEPTH_CNT = (PTR_W + 1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W:0]   count_nxt;

    // Head of queue is read straight from storage so a pop sees it the cycle after the push
    assign head = mem[rd_ptr];

    // Occupancy after this cycle's push/pop; simultaneous push and pop leave it unchanged
    always_comb begin
        count_nxt = count;
        if (push && !pop) begin
            count_nxt = count + 1'b1;
        end else if (!push && pop) begin
            count_nxt = count - 1'b1;
        end
    end

    // Storage write; contents need no reset because the pointers define validity
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    // Pointers wrap naturally at DEPTH; flags registered from the next occupancy
    always_ff @(posedge clk) begin
        if (!nrst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            full   <= 1'b0;
            empty  <= 1'b1;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            count <= count_nxt;
            full  <= (count_nxt == DEPTH_CNT);
            empty <= (count_nxt == '0);
        end
    end

endmodule

// File: rtl/uart_tx_buffered.sv
// rtl/uart_tx_buffered.sv - buffered 8N1 UART transmitter
module uart_tx_buffered
    import uart_tx_buffered_pkg::*;
#(
    parameter int CLKS_PER_BIT = UART_CLKS_PER_BIT,
    parameter int FIFO_DEPTH   = 16,
    parameter int PTR_W        = 4
) (
    input  logic                sysclk,
    input  logic                nrst,
    uart_tx_buffered_if.slave   bus,
    output logic                uart_tx
);

    localparam int              BAUD_W    = $clog2(CLKS_PER_BIT);
    localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);

    uart_state_t       state;
    uart_state_t       state_nxt;
    logic [BAUD_W-1:0] baud_cnt;
    logic [BAUD_W-1:0] baud_cnt_nxt;
    logic [2:0]        bit_idx;
    logic [2:0]        bit_idx_nxt;
    logic [7:0]        shift_reg;
    logic [7:0]        shift_nxt;
    logic              tx_nxt;
    logic              bit_done;
    logic              pop;
    logic              push;
    logic [7:0]        fifo_head;
    logic              fifo_full;
    logic              fifo_empty;
    logic [PTR_W:0]    fifo_count;
    logic              overflow;

    // A write slips in at full only when the head leaves on the same cycle
    assign push     = bus.wr_en && (!fifo_full || pop);
    assign bit_done = (baud_cnt == BAUD_LAST);

    assign bus.full     = fifo_full;
    assign bus.empty    = fifo_empty;
    assign bus.overflow = overflow;
    assign bus.busy     = (state != UART_ST_IDLE) || (fifo_count != '0);

    uart_tx_buffered_sync_fifo #(
        .WIDTH (8),
        .DEPTH (FIFO_DEPTH),
        .PTR_W (PTR_W)
    ) u_fifo (
        .clk       (sysclk),
        .nrst      (nrst),
        .push      (push),
        .push_data (bus.wr_data),
        .pop       (pop),
        .head      (fifo_head),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

    // Frame sequencing: next state, baud/bit counters, shifter and FIFO pop
    always_comb begin
        state_nxt    = state;
        baud_cnt_nxt = baud_cnt;
        bit_idx_nxt  = bit_idx;
        shift_nxt    = shift_reg;
        pop          = 1'b0;
        case (state)
            UART_ST_IDLE: begin
                if (!fifo_empty) begin
                    pop          = 1'b1;
                    shift_nxt    = fifo_head;
                    baud_cnt_nxt = '0;
                    state_nxt    = UART_ST_START;
                end
            end
            UART_ST_START: begin
                if (bit_done) begin
                    baud_cnt_nxt = '0;
                    bit_idx_nxt  = '0;
                    state_nxt    = UART_ST_DATA;
                end else begin
                    baud_cnt_nxt = baud_cnt + 1'b1;
                end
            end
            UART_ST_DATA: begin
                if (bit_done) begin
                    baud_cnt_nxt = '0;
                    shift_nxt    = {1'b0, shift_reg[7:1]};
                    if (bit_idx == 3'd7) begin
                        state_nxt = UART_ST_STOP;
                    end else begin
                        bit_idx_nxt = bit_idx + 1'b1;
                    end
                end else begin
                    baud_cnt_nxt = baud_cnt + 1'b1;
                end
            end
            UART_ST_STOP: begin
                if (bit_done) begin
                    baud_cnt_nxt = '0;
                    state_nxt    = UART_ST_IDLE;
                end else begin
                    baud_cnt_nxt = baud_cnt + 1'b1;
                end
            end
            default: begin
                state_nxt = UART_ST_IDLE;
            end
        endcase
    end

    // Line level for the coming cycle, taken from the next state so uart_tx is a pure register
    always_comb begin
        tx_nxt = 1'b1;
        case (state_nxt)
            UART_ST_START: tx_nxt = 1'b0;
            UART_ST_DATA:  tx_nxt = shift_nxt[0];
            default:       tx_nxt = 1'b1;
        endcase
    end

    // FSM and datapath registers; reset abandons any frame in flight
    always_ff @(posedge sysclk) begin
        if (!nrst) begin
            state     <= UART_ST_IDLE;
            baud_cnt  <= '0;
            bit_idx   <= '0;
            shift_reg <= '0;
            uart_tx   <= 1'b1;
        end else begin
            state     <= state_nxt;
            baud_cnt  <= baud_cnt_nxt;
            bit_idx   <= bit_idx_nxt;
            shift_reg <= shift_nxt;
            uart_tx   <= tx_nxt;
        end
    end

    // Sticky record of any write dropped against a full FIFO
    always_ff @(posedge sysclk) begin
        if (!nrst) begin
            overflow <= 1'b0;
        end else if (bus.wr_en && fifo_full && !pop) begin
            overflow <= 1'b1;
        end
    end

endmodule

// File: tb/tb_uart_tx_buffered.sv
// tb/tb_uart_tx_buffered.sv - self-checking bench for uart_tx_buffered
module tb_uart_tx_buffered;

    localparam int CPB   = 4;
    localparam int DEPTH = 4;
    localparam int FRAME = 10 * CPB;

    logic sysclk = 1'b0;
    logic nrst;
    logic uart_tx;

    uart_tx_buffered_if bus ();

    uart_tx_buffered #(
        .CLKS_PER_BIT (CPB),
        .FIFO_DEPTH   (DEPTH),
        .PTR_W        (2)
    ) dut (
        .sysclk  (sysclk),
        .nrst    (nrst),
        .bus     (bus),
        .uart_tx (uart_tx)
    );

    always #5 sysclk = ~sysclk;

    int checks = 0;
    int errors = 0;

    // Reference model: queued bytes, cycles left in the current frame, byte on the wire
    logic [7:0] m_q[$];
    logic [7:0] log_q[$];
    int         m_rem = 0;
    logic       m_ovf = 1'b0;
    logic [7:0] m_cur = 8'h00;

    // Independent line decoder
    logic       dec_active = 1'b0;
    int         dec_t = 0;
    logic [7:0] dec_byte = 8'h00;
    logic       prev_line = 1'b1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic exp_line();
        int t;
        int b;
        if (m_rem == 0) return 1'b1;
        t = FRAME - m_rem;
        b = t / CPB;
        if (b == 0) return 1'b0;
        if (b <= 8) return m_cur[b-1];
        return 1'b1;
    endfunction

    task automatic model_update(input logic w, input logic [7:0] d, input logic rn);
        logic pop;
        logic acc;
        if (!rn) begin
            m_q.delete();
            log_q.delete();
            m_rem = 0;
            m_ovf = 1'b0;
            dec_active = 1'b0;
        end else begin
            pop = (m_rem == 0) && (m_q.size() > 0);
            acc = w && ((m_q.size() < DEPTH) || pop);
            if (w && !acc) m_ovf = 1'b1;
            if (pop) begin
                m_cur = m_q.pop_front();
                m_rem = FRAME;
            end else if (m_rem > 0) begin
                m_rem--;
            end
            if (acc) begin
                m_q.push_back(d);
                log_q.push_back(d);
            end
        end
    endtask

    task automatic decode();
        logic [31:0] exp;
        if (!dec_active) begin
            if (prev_line && uart_tx == 1'b0) begin
                dec_active = 1'b1;
                dec_t = 0;
            end
        end else begin
            dec_t++;
            if (dec_t >= 6 && dec_t <= 34 && (dec_t % CPB) == 2) dec_byte[(dec_t - 6) / CPB] = uart_tx;
            if (dec_t == 38) begin
                chk("stop_bit", {31'd0, uart_tx}, 32'd1);
                exp = 32'h1FF;
                if (log_q.size() > 0) exp = {24'd0, log_q.pop_front()};
                chk("decoded_byte", {24'd0, dec_byte}, exp);
                dec_active = 1'b0;
            end
        end
        prev_line = uart_tx;
    endtask

    task automatic step(input logic w, input logic [7:0] d, input logic rn);
        bus.wr_en   = w;
        bus.wr_data = d;
        nrst        = rn;
        @(posedge sysclk);
        model_update(w, d, rn);
        #1;
        chk("uart_tx",  {31'd0, uart_tx},      {31'd0, exp_line()});
        chk("empty",    {31'd0, bus.empty},    {31'd0, m_q.size() == 0});
        chk("full",     {31'd0, bus.full},     {31'd0, m_q.size() == DEPTH});
        chk("busy",     {31'd0, bus.busy},     {31'd0, (m_rem > 0) || (m_q.size() > 0)});
        chk("overflow", {31'd0, bus.overflow}, {31'd0, m_ovf});
        decode();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 8'h00, 1'b1);
    endtask

    initial begin
        bus.wr_en   = 1'b0;
        bus.wr_data = 8'h00;
        nrst        = 1'b0;

        // Reset held three cycles
        for (int i = 0; i < 3; i++) step(1'b0, 8'h00, 1'b0);

        // Single byte
        step(1'b1, 8'hA5, 1'b1);
        idle(FRAME + 5);

        // Burst of five consecutive writes
        for (int i = 1; i <= 5; i++) step(1'b1, 8'(i), 1'b1);
        idle(5 * (FRAME + 1) + 5);

        // Continuous writes: fill, drop, and push on the pop cycle at full
        for (int i = 0; i < 3 * FRAME; i++) step(1'b1, 8'($urandom), 1'b1);
        idle(5 * (FRAME + 1) + 5);

        // Reset during data bit 3, then a fresh frame
        step(1'b1, 8'($urandom), 1'b1);
        for (int i = 0; i < 2 * FRAME && m_rem != FRAME - 17; i++) idle(1);
        chk("reach_bit3", 32'(m_rem), 32'(FRAME - 17));
        step(1'b0, 8'h00, 1'b0);
        step(1'b1, 8'($urandom), 1'b1);
        idle(FRAME + 5);

        // Twenty writes paced one per frame: pointers wrap five times
        for (int i = 0; i < 20; i++) begin
            step(1'b1, 8'($urandom), 1'b1);
            idle(FRAME + 1);
        end

        // Random sparse traffic
        for (int i = 0; i < 400; i++) step(($urandom % 8) == 0, 8'($urandom), 1'b1);
        idle(5 * (FRAME + 1) + 5);

        chk("all_decoded", 32'(log_q.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
